// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Purpose  : Shared opcode, ALU-op and ALU-B-source encodings plus the
//             state enumeration of the multi-cycle control unit.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Instruction opcodes (instr[15:12]); anything above OP_SW is illegal
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ANDI  = 4'd2;
    localparam logic [3:0] OP_ORI   = 4'd3;
    localparam logic [3:0] OP_NORI  = 4'd4;
    localparam logic [3:0] OP_BEQ   = 4'd5;
    localparam logic [3:0] OP_BNE   = 4'd6;
    localparam logic [3:0] OP_SLTI  = 4'd7;
    localparam logic [3:0] OP_LW    = 4'd8;
    localparam logic [3:0] OP_SW    = 4'd9;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    // ALU B-operand source select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Controller states
    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_BRANCH = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_R   = 4'd9,
        S_WB_I   = 4'd10,
        S_WB_MEM = 4'd11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit_if
//  Purpose  : Bundle between the multi-cycle controller (master) and the
//             datapath / memory side (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic                pc_src;
    logic                ir_write;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                reg_dest;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                instr_done;
    logic                illegal_op;
    logic                bus_error;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, pc_src, ir_write, i_or_d,
               mem_read, mem_write, reg_dest, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, instr_done, illegal_op,
               bus_error, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, pc_src, ir_write, i_or_d,
               mem_read, mem_write, reg_dest, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, instr_done, illegal_op,
               bus_error, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/mem_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : mem_watchdog
//  Purpose  : Counts memory wait cycles; flags expiry when the count has
//             reached MEM_TIMEOUT and the memory is still not ready.
//             MEM_TIMEOUT = 0 disables expiry.
//  Revision : 1.0  initial release
// ============================================================================
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);
    localparam int         CW        = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(MEM_TIMEOUT);
    localparam bit         C_ENABLED = (MEM_TIMEOUT != 0);

    logic [CW-1:0] r_cnt;

    // Expiry takes effect in a wait cycle that starts with the count at the limit
    assign o_expire = C_ENABLED && i_enable && (r_cnt == C_LIMIT);

    // Wait counter: cleared outside waits and on expiry, counts stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_expire) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_unit
//  Purpose  : Moore-style controller for the 16-bit multi-cycle MIPS datapath
//             with shared memory port, memory watchdog, illegal-opcode flag
//             and retired-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    multicycle_control_unit_if.master bus
);
    state_t              r_state;
    state_t              w_next;
    logic [OPCODE_W-1:0] r_opcode;
    logic [CNT_W-1:0]    r_count;
    logic                w_in_wait;
    logic                w_wd_en;
    logic                w_wd_clr;
    logic                w_expire;

    // Only the memory-access states can stall on mem_ready
    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
    assign w_wd_en   = w_in_wait && !bus.mem_ready;
    assign w_wd_clr  = !w_wd_en;

    mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_wd_clr),
        .i_enable (w_wd_en),
        .o_expire (w_expire)
    );

    assign bus.instr_count = r_count;

    // State register, opcode latch on IR load, retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RESET;
            r_opcode <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && bus.mem_ready) begin
                r_opcode <= bus.opcode;
            end
            if (bus.instr_done) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Next-state and output decode from state and latched opcode
    always_comb begin
        w_next            = r_state;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_src        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_dest      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALU_OP_W'(ALU_ADD);
        bus.instr_done    = 1'b0;
        bus.illegal_op    = 1'b0;
        bus.bus_error     = w_expire;

        case (r_state)
            S_RESET: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_TWO;
                if (bus.mem_ready) begin
                    bus.pc_write = 1'b1;
                    bus.ir_write = 1'b1;
                    w_next       = S_DECODE;
                end else if (w_expire) begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SH;
                case (r_opcode)
                    OPCODE_W'(OP_RTYPE): w_next = S_EXEC_R;
                    OPCODE_W'(OP_ADDI),
                    OPCODE_W'(OP_ANDI),
                    OPCODE_W'(OP_ORI),
                    OPCODE_W'(OP_NORI),
                    OPCODE_W'(OP_SLTI):  w_next = S_EXEC_I;
                    OPCODE_W'(OP_BEQ),
                    OPCODE_W'(OP_BNE):   w_next = S_BRANCH;
                    OPCODE_W'(OP_LW),
                    OPCODE_W'(OP_SW):    w_next = S_ADDR;
                    default: begin
                        bus.illegal_op = 1'b1;
                        bus.instr_done = 1'b1;
                        w_next         = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_OP_W'(ALU_RTYPE);
                w_next        = S_WB_R;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                case (r_opcode)
                    OPCODE_W'(OP_ANDI): bus.alu_op = ALU_OP_W'(ALU_AND);
                    OPCODE_W'(OP_ORI):  bus.alu_op = ALU_OP_W'(ALU_OR);
                    OPCODE_W'(OP_NORI): bus.alu_op = ALU_OP_W'(ALU_NOR);
                    OPCODE_W'(OP_SLTI): bus.alu_op = ALU_OP_W'(ALU_SLT);
                    default:            bus.alu_op = ALU_OP_W'(ALU_ADD);
                endcase
                w_next = S_WB_I;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_OP_W'(ALU_SUB);
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 1'b1;
                bus.branch_ne     = (r_opcode == OPCODE_W'(OP_BNE));
                bus.instr_done    = 1'b1;
                w_next            = S_FETCH;
            end
            S_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                w_next        = (r_opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_WB_MEM;
                end else if (w_expire) begin
                    w_next = S_FETCH;
                end
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    w_next         = S_FETCH;
                end else if (w_expire) begin
                    w_next = S_FETCH;
                end
            end
            S_WB_R: begin
                bus.reg_write  = 1'b1;
                bus.reg_dest   = 1'b1;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            S_WB_I: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
                w_next         = S_FETCH;
            end
            default: begin
                w_next = S_RESET;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control_unit
//  Purpose  : Directed self-checking bench for multicycle_control_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control_unit;

    // Output vector bit positions:
    // 19 pc_write, 18 pc_write_cond, 17 branch_ne, 16 pc_src, 15 ir_write,
    // 14 i_or_d, 13 mem_read, 12 mem_write, 11 reg_dest, 10 mem_to_reg,
    // 9 reg_write, 8 alu_src_a, 7:6 alu_src_b, 5:3 alu_op, 2 instr_done,
    // 1 illegal_op, 0 bus_error
    localparam logic [19:0] E_PCW   = 20'd1 << 19;
    localparam logic [19:0] E_PWC   = 20'd1 << 18;
    localparam logic [19:0] E_BNE   = 20'd1 << 17;
    localparam logic [19:0] E_PCSRC = 20'd1 << 16;
    localparam logic [19:0] E_IRW   = 20'd1 << 15;
    localparam logic [19:0] E_IORD  = 20'd1 << 14;
    localparam logic [19:0] E_MR    = 20'd1 << 13;
    localparam logic [19:0] E_MW    = 20'd1 << 12;
    localparam logic [19:0] E_RD    = 20'd1 << 11;
    localparam logic [19:0] E_M2R   = 20'd1 << 10;
    localparam logic [19:0] E_RW    = 20'd1 << 9;
    localparam logic [19:0] E_SRCA  = 20'd1 << 8;
    localparam logic [19:0] E_SB2   = 20'd1 << 6;
    localparam logic [19:0] E_SBIMM = 20'd2 << 6;
    localparam logic [19:0] E_SBSH  = 20'd3 << 6;
    localparam logic [19:0] E_SUB   = 20'd1 << 3;
    localparam logic [19:0] E_OR    = 20'd3 << 3;
    localparam logic [19:0] E_SLT   = 20'd5 << 3;
    localparam logic [19:0] E_RTYPE = 20'd7 << 3;
    localparam logic [19:0] E_DONE  = 20'd1 << 2;
    localparam logic [19:0] E_ILL   = 20'd1 << 1;
    localparam logic [19:0] E_BERR  = 20'd1;

    // Hand-decoded per-state output words
    localparam logic [19:0] X_FETCH_RDY  = E_PCW | E_IRW | E_MR | E_SB2;
    localparam logic [19:0] X_FETCH_WAIT = E_MR | E_SB2;
    localparam logic [19:0] X_DECODE     = E_SBSH;
    localparam logic [19:0] X_DEC_ILL    = E_SBSH | E_DONE | E_ILL;
    localparam logic [19:0] X_EXEC_R     = E_SRCA | E_RTYPE;
    localparam logic [19:0] X_WB_R       = E_RW | E_RD | E_DONE;
    localparam logic [19:0] X_WB_I       = E_RW | E_DONE;
    localparam logic [19:0] X_ADDR       = E_SRCA | E_SBIMM;
    localparam logic [19:0] X_MEM_RD     = E_MR | E_IORD;
    localparam logic [19:0] X_WB_MEM     = E_RW | E_M2R | E_DONE;
    localparam logic [19:0] X_MEM_WR     = E_MW | E_IORD;
    localparam logic [19:0] X_BEQ        = E_SRCA | E_SUB | E_PWC | E_PCSRC | E_DONE;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    multicycle_control_unit_if #(.OPCODE_W(4), .ALU_OP_W(3), .CNT_W(16)) ctl_if ();

    multicycle_control_unit #(
        .OPCODE_W    (4),
        .ALU_OP_W    (3),
        .MEM_TIMEOUT (3),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ctl_if)
    );

    logic [19:0] w_obs;
    assign w_obs = {ctl_if.pc_write, ctl_if.pc_write_cond, ctl_if.branch_ne,
                    ctl_if.pc_src, ctl_if.ir_write, ctl_if.i_or_d,
                    ctl_if.mem_read, ctl_if.mem_write, ctl_if.reg_dest,
                    ctl_if.mem_to_reg, ctl_if.reg_write, ctl_if.alu_src_a,
                    ctl_if.alu_src_b, ctl_if.alu_op, ctl_if.instr_done,
                    ctl_if.illegal_op, ctl_if.bus_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Apply inputs mid-cycle (after the negedge) and check the decoded outputs
    task automatic run_cycle(input string tag, input logic rdy, input logic [3:0] op,
                             input logic [19:0] exp);
        @(negedge clk);
        ctl_if.mem_ready = rdy;
        ctl_if.opcode    = op;
        #1;
        check(tag, {12'd0, w_obs}, {12'd0, exp});
    endtask

    initial begin
        n_total          = 0;
        n_pass           = 0;
        rst_n            = 1'b0;
        ctl_if.mem_ready = 1'b1;
        ctl_if.opcode    = 4'h0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_outputs", {12'd0, w_obs}, 32'd0);
        check("rst_count", {16'd0, ctl_if.instr_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_cycle", {12'd0, w_obs}, 32'd0);

        // R-type: 4 cycles
        run_cycle("r_fetch",  1'b1, 4'h0, X_FETCH_RDY);
        run_cycle("r_decode", 1'b1, 4'hF, X_DECODE);
        run_cycle("r_exec",   1'b1, 4'hF, X_EXEC_R);
        run_cycle("r_wb",     1'b1, 4'hF, X_WB_R);

        // ori: I-type with OR
        run_cycle("ori_fetch", 1'b1, 4'h3, X_FETCH_RDY);
        check("cnt_after_r", {16'd0, ctl_if.instr_count}, 32'd1);
        run_cycle("ori_decode", 1'b1, 4'hF, X_DECODE);
        run_cycle("ori_exec",   1'b1, 4'hF, E_SRCA | E_SBIMM | E_OR);
        run_cycle("ori_wb",     1'b1, 4'hF, X_WB_I);

        // lw with 3 stall cycles; ready arrives exactly when the timeout would fire
        run_cycle("lw_fetch", 1'b1, 4'h8, X_FETCH_RDY);
        check("cnt_after_ori", {16'd0, ctl_if.instr_count}, 32'd2);
        run_cycle("lw_decode", 1'b1, 4'hF, X_DECODE);
        run_cycle("lw_addr",   1'b1, 4'hF, X_ADDR);
        for (int i = 0; i < 3; i++) begin
            run_cycle("lw_mem_wait", 1'b0, 4'hF, X_MEM_RD);
        end
        run_cycle("lw_mem_rdy", 1'b1, 4'hF, X_MEM_RD);
        run_cycle("lw_wb",      1'b1, 4'hF, X_WB_MEM);

        // bne then beq
        run_cycle("bne_fetch", 1'b1, 4'h6, X_FETCH_RDY);
        check("cnt_after_lw", {16'd0, ctl_if.instr_count}, 32'd3);
        run_cycle("bne_decode", 1'b1, 4'hF, X_DECODE);
        run_cycle("bne_branch", 1'b1, 4'hF, X_BEQ | E_BNE);
        run_cycle("beq_fetch",  1'b1, 4'h5, X_FETCH_RDY);
        run_cycle("beq_decode", 1'b1, 4'hF, X_DECODE);
        run_cycle("beq_branch", 1'b1, 4'hF, X_BEQ);

        // Illegal opcode 1100: 2 cycles, counted as retired
        run_cycle("ill_fetch", 1'b1, 4'hC, X_FETCH_RDY);
        check("cnt_after_br", {16'd0, ctl_if.instr_count}, 32'd5);
        run_cycle("ill_decode", 1'b1, 4'hF, X_DEC_ILL);

        // slti follows immediately, proving FETCH after the illegal decode
        run_cycle("slt_fetch", 1'b1, 4'h7, X_FETCH_RDY);
        check("cnt_after_ill", {16'd0, ctl_if.instr_count}, 32'd6);
        run_cycle("slt_decode", 1'b1, 4'hF, X_DECODE);
        run_cycle("slt_exec",   1'b1, 4'hF, E_SRCA | E_SBIMM | E_SLT);
        run_cycle("slt_wb",     1'b1, 4'hF, X_WB_I);

        // sw with memory never ready: bus error after 3 wait cycles
        run_cycle("sw_fetch", 1'b1, 4'h9, X_FETCH_RDY);
        run_cycle("sw_decode", 1'b1, 4'hF, X_DECODE);
        run_cycle("sw_addr",   1'b1, 4'hF, X_ADDR);
        for (int i = 0; i < 3; i++) begin
            run_cycle("sw_mem_wait", 1'b0, 4'hF, X_MEM_WR);
        end
        run_cycle("sw_timeout", 1'b0, 4'hF, X_MEM_WR | E_BERR);

        // Back in FETCH; stall it into a fetch timeout as well
        for (int i = 0; i < 3; i++) begin
            run_cycle("fetch_wait", 1'b0, 4'hF, X_FETCH_WAIT);
        end
        check("cnt_after_timeout", {16'd0, ctl_if.instr_count}, 32'd7);
        run_cycle("fetch_timeout", 1'b0, 4'hF, X_FETCH_WAIT | E_BERR);
        run_cycle("refetch",       1'b1, 4'h9, X_FETCH_RDY);

        // Reset asserted in the middle of MEM_WR
        run_cycle("sw2_decode", 1'b1, 4'hF, X_DECODE);
        run_cycle("sw2_addr",   1'b1, 4'hF, X_ADDR);
        run_cycle("sw2_mem_wait", 1'b0, 4'hF, X_MEM_WR);
        @(negedge clk);
        ctl_if.mem_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {12'd0, w_obs}, 32'd0);
        check("midrst_count", {16'd0, ctl_if.instr_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_reset_cycle", {12'd0, w_obs}, 32'd0);
        run_cycle("post_rst_fetch", 1'b0, 4'h0, X_FETCH_WAIT);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle combinational control unit of the 16-bit MIPS CPU; drives a multi-cycle datapath with one shared memory port, a single ALU, and IR/PC write enables.
- Moore FSM. Opcode latched on IR load. Memory ready/wait handshake with a watchdog timeout. Illegal opcodes flagged. Retired-instruction counter.

Parameters:
- OPCODE_W, 4, opcode width. Must be >=4. Values 0..9 are legal; all others are illegal.
- ALU_OP_W, 3, alu_op width. Must be >=3. Upper bits are zero.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready. 0 disables the watchdog.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  OPCODE_W  instr[15:12] from memory data; sampled in FETCH when mem_ready=1
- mem_ready  in  1  memory has completed the current read or write
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when the branch condition holds
- branch_ne  out  1  1 = bne (take branch when zero=0); 0 = beq
- pc_src  out  1  0 = ALU result, 1 = ALUOut register (branch target)
- ir_write  out  1  IR load
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_dest  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR to register file
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 2, 10 = sign-extended immediate, 11 = sign-extended immediate << 1
- alu_op  out  ALU_OP_W  000 add, 001 sub, 010 and, 011 or, 100 nor, 101 slt, 111 R-type (funct)
- instr_done  out  1  one-cycle pulse in the last cycle of a retired instruction
- illegal_op  out  1  one-cycle pulse, in DECODE, when the opcode is illegal
- bus_error  out  1  one-cycle pulse when the watchdog expires
- instr_count  out  CNT_W  number of retired instructions; wraps modulo 2^CNT_W

Behaviour:
- rst_n=0: state goes to RESET immediately. opcode_q, wait counter and instr_count clear. Every output is 0.
- Reset asserted mid-operation aborts the instruction with no further pulses.
- RESET lasts exactly one cycle after reset deasserts, then goes to FETCH.
- Outputs are decoded from state and opcode_q only; they do not depend on the opcode input.
- Exceptions: the mem_ready-qualified strobes pc_write, ir_write and instr_done in MEM_WR.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add.
  - When mem_ready=1: pc_write=1, ir_write=1, opcode_q<=opcode, go to DECODE. Otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add. Next state by opcode_q:
  - 0 → EXEC_R
  - 1–4 and 7 → EXEC_I
  - 5–6 → BRANCH
  - 8–9 → ADDR
  - other → FETCH, with illegal_op=1 and instr_done=1
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=111; go to WB_R.
- EXEC_I: alu_src_a=1, alu_src_b=10; alu_op per opcode (1 add, 2 and, 3 or, 4 nor, 7 slt); go to WB_I.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_src=1, branch_ne=(opcode_q==6), instr_done=1; go to FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=add; go to MEM_RD (opcode 8) or MEM_WR (opcode 9).
- MEM_RD: mem_read=1, i_or_d=1; on mem_ready go to WB_MEM.
- MEM_WR: mem_write=1, i_or_d=1; on mem_ready: instr_done=1, go to FETCH.
- WB_R: reg_write=1, reg_dest=1, instr_done=1; go to FETCH.
- WB_I: reg_write=1, reg_dest=0, mem_to_reg=0, instr_done=1; go to FETCH.
- WB_MEM: reg_write=1, reg_dest=0, mem_to_reg=1, instr_done=1; go to FETCH.
- Latency in cycles, with mem_ready always 1: R-type/I-type 4, branch 3, lw 5, sw 4, illegal 2.
- Watchdog:
  - The wait counter clears on entry to FETCH, MEM_RD or MEM_WR, and increments each cycle in that state with mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: bus_error=1 for one cycle, go to FETCH with no PC, IR or register write and no instr_done.
  - A timeout in FETCH re-fetches from the same PC.
  - mem_ready=1 in the same cycle the timeout would fire: the ready wins and no bus_error is raised.
- instr_count increments on every instr_done pulse, including illegal opcodes.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the opcode constants OP_RTYPE..OP_SW
  - the alu_op constants ALU_ADD..ALU_RTYPE
  - the alu_src_b encodings
  - the state enum, 4 bits, RESET=0
- Sub-module mem_watchdog: wait counter, clear/enable inputs, expire output, parametrised by MEM_TIMEOUT.

Test Plan:
- Reset, then opcode=0, mem_ready=1 → FETCH, DECODE, EXEC_R, WB_R. reg_write=1, reg_dest=1 and instr_done=1 in cycle 4. instr_count=1.
- lw (8) with mem_ready low for 3 cycles in MEM_RD → mem_read and i_or_d held at 1 for 4 cycles, then WB_MEM with mem_to_reg=1. Total 8 cycles.
- bne (6) → BRANCH cycle shows pc_write_cond=1, branch_ne=1, pc_src=1, alu_op=001. beq (5) gives branch_ne=0.
- Opcode 4'b1100 → illegal_op and instr_done pulse in DECODE, then FETCH next cycle. No reg_write or mem_write at any point.
- MEM_TIMEOUT=3, sw (9) with mem_ready=0 held → bus_error for one cycle after 3 wait cycles, state returns to FETCH, mem_write drops, instr_count unchanged.
- rst_n pulsed low during MEM_WR → all outputs 0 immediately, instr_count=0, one RESET cycle, then mem_read=1 in FETCH.
